// File: rtl/video_timing_ctrl_pkg.sv
// Shared widths, reset timing defaults and timing-set types for the raster
// timing controller.
package video_timing_pkg;

  localparam int VT_W         = 11;
  localparam int VT_MIN_TOTAL = 15;

  localparam logic [VT_W-1:0] VT_RST_HT  = 11'd799;
  localparam logic [VT_W-1:0] VT_RST_HSE = 11'd95;
  localparam logic [VT_W-1:0] VT_RST_HDS = 11'd143;
  localparam logic [VT_W-1:0] VT_RST_HDE = 11'd783;
  localparam logic [VT_W-1:0] VT_RST_VT  = 11'd524;
  localparam logic [VT_W-1:0] VT_RST_VSE = 11'd1;
  localparam logic [VT_W-1:0] VT_RST_VDS = 11'd34;
  localparam logic [VT_W-1:0] VT_RST_VDE = 11'd514;

  typedef struct packed {
    logic [VT_W-1:0] total;
    logic [VT_W-1:0] sync_end;
    logic [VT_W-1:0] disp_start;
    logic [VT_W-1:0] disp_end;
  } vt_axis_t;

  typedef struct packed {
    vt_axis_t h;
    vt_axis_t v;
  } vt_timing_t;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } vt_cfg_state_t;

endpackage

// File: rtl/video_timing_ctrl_if.sv
// Configuration strobe and raster outputs of the timing controller; the
// slave side is the controller, the master side is the host/consumer.
interface video_timing_ctrl_if
  import video_timing_pkg::*;
#(
  parameter int W = VT_W
);

  logic [W-1:0] cfg_h_total;
  logic [W-1:0] cfg_h_sync_end;
  logic [W-1:0] cfg_h_disp_start;
  logic [W-1:0] cfg_h_disp_end;
  logic [W-1:0] cfg_v_total;
  logic [W-1:0] cfg_v_sync_end;
  logic [W-1:0] cfg_v_disp_start;
  logic [W-1:0] cfg_v_disp_end;
  logic         cfg_valid;
  logic         cfg_pending;
  logic         cfg_err;
  logic [W-1:0] px;
  logic [W-1:0] py;
  logic [W-1:0] xstart;
  logic [W-1:0] xend;
  logic [W-1:0] ystart;
  logic [W-1:0] yend;
  logic         frame_start;
  logic         hsync;
  logic         vsync;
  logic         de;

  modport master (
    output cfg_h_total, cfg_h_sync_end, cfg_h_disp_start, cfg_h_disp_end,
    output cfg_v_total, cfg_v_sync_end, cfg_v_disp_start, cfg_v_disp_end,
    output cfg_valid,
    input  cfg_pending, cfg_err, px, py, xstart, xend, ystart, yend,
    input  frame_start, hsync, vsync, de
  );

  modport slave (
    input  cfg_h_total, cfg_h_sync_end, cfg_h_disp_start, cfg_h_disp_end,
    input  cfg_v_total, cfg_v_sync_end, cfg_v_disp_start, cfg_v_disp_end,
    input  cfg_valid,
    output cfg_pending, cfg_err, px, py, xstart, xend, ystart, yend,
    output frame_start, hsync, vsync, de
  );

endinterface

// File: rtl/video_timing_ctrl_vt_delay.sv
// Fixed-depth delay line for {hsync, vsync, de}, cleared by reset.
module vt_delay
  import video_timing_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [2:0] din_i,
  output logic [2:0] dout_o
);

  logic [2:0] sr_q [DEPTH];

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing controller: beam counters, double-buffered timing set and
// sync/de outputs delayed to line up with the pattern generator's RGB.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int           W        = VT_W,
  parameter int           PIPE_DLY = 3,
  parameter logic [W-1:0] RST_HT   = VT_RST_HT,
  parameter logic [W-1:0] RST_HSE  = VT_RST_HSE,
  parameter logic [W-1:0] RST_HDS  = VT_RST_HDS,
  parameter logic [W-1:0] RST_HDE  = VT_RST_HDE,
  parameter logic [W-1:0] RST_VT   = VT_RST_VT,
  parameter logic [W-1:0] RST_VSE  = VT_RST_VSE,
  parameter logic [W-1:0] RST_VDS  = VT_RST_VDS,
  parameter logic [W-1:0] RST_VDE  = VT_RST_VDE
) (
  input logic                pclk,
  input logic                rst_n,
  video_timing_ctrl_if.slave bus
);

  localparam vt_timing_t RST_SET = '{
    h: '{total: RST_HT, sync_end: RST_HSE, disp_start: RST_HDS, disp_end: RST_HDE},
    v: '{total: RST_VT, sync_end: RST_VSE, disp_start: RST_VDS, disp_end: RST_VDE}
  };

  vt_timing_t    act_q, pend_q, cfg_in;
  vt_cfg_state_t state_q;
  logic [W-1:0]  px_q, px_d, py_q, py_d;
  logic          run_q, fs_q, fs_d, err_q;
  logic          h_wrap, fb, cfg_ok, cfg_take;
  logic          hs_raw, vs_raw, de_raw;
  logic [2:0]    sync_dly;

  function automatic logic axis_ok(input vt_axis_t a);
    return (a.total >= VT_W'(VT_MIN_TOTAL)) && (a.sync_end <= a.disp_start) &&
           (a.disp_start < a.disp_end) && (a.disp_end <= a.total);
  endfunction

  always_comb begin
    cfg_in.h.total      = bus.cfg_h_total;
    cfg_in.h.sync_end   = bus.cfg_h_sync_end;
    cfg_in.h.disp_start = bus.cfg_h_disp_start;
    cfg_in.h.disp_end   = bus.cfg_h_disp_end;
    cfg_in.v.total      = bus.cfg_v_total;
    cfg_in.v.sync_end   = bus.cfg_v_sync_end;
    cfg_in.v.disp_start = bus.cfg_v_disp_start;
    cfg_in.v.disp_end   = bus.cfg_v_disp_end;
    cfg_ok   = axis_ok(cfg_in.h) && axis_ok(cfg_in.v);
    cfg_take = bus.cfg_valid && cfg_ok;
  end

  // Beam counters hold for one cycle after reset so the first post-reset
  // cycle presents px=py=0 together with frame_start.
  always_comb begin
    h_wrap = (px_q == act_q.h.total);
    fb     = run_q && h_wrap && (py_q == act_q.v.total);
    px_d   = px_q;
    py_d   = py_q;
    if (run_q) begin
      if (h_wrap) begin
        px_d = '0;
        py_d = (py_q == act_q.v.total) ? '0 : py_q + 1'b1;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
    fs_d = (px_d == '0) && (py_d == '0);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      px_q  <= '0;
      py_q  <= '0;
      run_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      px_q  <= px_d;
      py_q  <= py_d;
      run_q <= 1'b1;
      fs_q  <= fs_d;
    end
  end

  // A strobe landing on the frame boundary bypasses the pending set.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CFG_IDLE;
      act_q   <= RST_SET;
      pend_q  <= RST_SET;
      err_q   <= 1'b0;
    end else begin
      err_q <= bus.cfg_valid && !cfg_ok;
      if (cfg_take && fb) begin
        act_q   <= cfg_in;
        state_q <= CFG_IDLE;
      end else if (cfg_take) begin
        pend_q  <= cfg_in;
        state_q <= CFG_PEND;
      end else if (fb && (state_q == CFG_PEND)) begin
        act_q   <= pend_q;
        state_q <= CFG_IDLE;
      end
    end
  end

  always_comb begin
    hs_raw = (px_q < act_q.h.sync_end);
    vs_raw = (py_q < act_q.v.sync_end);
    de_raw = (px_q > act_q.h.disp_start) && (px_q <= act_q.h.disp_end) &&
             (py_q > act_q.v.disp_start) && (py_q <= act_q.v.disp_end);
  end

  vt_delay #(.DEPTH(PIPE_DLY)) u_sync_dly (
    .pclk  (pclk),
    .rst_n (rst_n),
    .din_i ({hs_raw, vs_raw, de_raw}),
    .dout_o(sync_dly)
  );

  assign bus.px          = px_q;
  assign bus.py          = py_q;
  assign bus.frame_start = fs_q;
  assign bus.cfg_pending = (state_q == CFG_PEND);
  assign bus.cfg_err     = err_q;
  assign bus.xstart      = act_q.h.disp_start;
  assign bus.xend        = act_q.h.disp_end;
  assign bus.ystart      = act_q.v.disp_start;
  assign bus.yend        = act_q.v.disp_end;
  assign bus.hsync       = sync_dly[2];
  assign bus.vsync       = sync_dly[1];
  assign bus.de          = sync_dly[0];

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Programmable raster timing controller that sequences the pixel-clock video test-pattern datapath. Generates the `px`/`py` beam counters and the active-window bounds consumed by the pattern generator. Produces `hsync`/`vsync`/`de` delayed to align with the pattern generator's 3-cycle RGB latency. Timing changes are double-buffered and take effect only at a frame boundary, so a mode change never tears a frame.

## Interface
Parameters:
- `W`, 11, width of all coordinate/timing values
- `PIPE_DLY`, 3, cycles of sync/`de` delay; equals the pattern generator's latency
- `RST_HT`/`RST_HSE`/`RST_HDS`/`RST_HDE`, 799/95/143/783, reset horizontal total, sync end, display start, display end
- `RST_VT`/`RST_VSE`/`RST_VDS`/`RST_VDE`, 524/1/34/514, reset vertical equivalents

Ports:
- `pclk`  in  1  pixel clock, the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `cfg_h_total`, `cfg_h_sync_end`, `cfg_h_disp_start`, `cfg_h_disp_end`  in  W each  requested horizontal timing
- `cfg_v_total`, `cfg_v_sync_end`, `cfg_v_disp_start`, `cfg_v_disp_end`  in  W each  requested vertical timing
- `cfg_valid`  in  1  one-cycle strobe: capture all `cfg_*` inputs
- `cfg_pending`  out  1  a captured config awaits the frame boundary
- `cfg_err`  out  1  one-cycle pulse: last strobe was rejected
- `px`, `py`  out  W  current beam position, registered
- `xstart`, `xend`, `ystart`, `yend`  out  W  active display-start/display-end values currently in effect
- `frame_start`  out  1  one-cycle pulse when `px`=0 and `py`=0
- `hsync`, `vsync`, `de`  out  1  active-high; delayed by `PIPE_DLY` cycles

## Operation
- Active timing set (A): registers, reset to the `RST_*` values. Pending set (P): registers, reset to the same values.
- Counters:
  - `px` increments each cycle.
  - At `px`==A.h_total, `px` wraps to 0 and `py` increments.
  - At `py`==A.v_total together with `px` wrap, `py` wraps to 0. This cycle is the frame boundary (FB).
- Sync and display-enable terms, computed before the delay line:
  - `hsync_raw` = `px` < A.h_sync_end.
  - `vsync_raw` = `py` < A.v_sync_end.
  - `de_raw` = (A.h_disp_start < `px` <= A.h_disp_end) && (A.v_disp_start < `py` <= A.v_disp_end).
- Config state machine, states IDLE and PEND:
  - IDLE + valid strobe → capture `cfg_*` into P; go to PEND.
  - PEND + valid strobe → overwrite P; stay in PEND (last write wins).
  - PEND + FB → copy P into A; go to IDLE.
  - Strobe in the same cycle as FB, from either state → the new `cfg_*` values go directly into A; end in IDLE.
- Validity: a strobe is valid only if all of the following hold:
  - total >= 15 in both axes
  - sync_end <= disp_start
  - disp_start < disp_end <= total
- An invalid strobe is ignored: state, A and P are unchanged, and `cfg_err` pulses the next cycle.
- `cfg_pending` = (state == PEND).
- `xstart`/`xend`/`ystart`/`yend` are driven directly from A.

## Timing
- Reset state (async assert): `px`=`py`=0, A=P=`RST_*`, state IDLE, delay line cleared. Consequently `hsync`=`vsync`=`de`=0, `frame_start`=0, `cfg_pending`=0, `cfg_err`=0.
- First cycle after `rst_n` deasserts: `px`=0, `py`=0, `frame_start`=1.
- `hsync`/`vsync`/`de` lag the `px`/`py` value they describe by exactly `PIPE_DLY` cycles. They are therefore coincident with the pattern generator's RGB outputs for that pixel.
- An A update at FB takes effect on the cycle `px`=0 of the new frame. Counter compares on that cycle already use the new values.
- The delay line is not flushed on an A update: the last `PIPE_DLY` pixels of the old frame still emerge.
- `frame_start` is not delayed. It is registered alongside `px`/`py`.
- Reset mid-frame or mid-PEND: discard P and return to `RST_*` immediately.

## Structure
- Shared package `video_timing_pkg`: the `W` default, the `RST_*` defaults, the minimum-total constant (15), and a packed timing-set type (4 × W per axis) used for A, P and `cfg_*`.
- One sub-module, `vt_delay`: a `PIPE_DLY`-deep, 3-bit shift register with async reset to 0.
- The validity check is combinational logic in the top level.

## Test plan
- Reset defaults, run 2 frames → `frame_start` period = 800×525 = 420000 cycles. `hsync` high for 95 cycles per line. `de` high for 640 cycles on each of 480 lines, first `de` at `px`=144 + 3 cycles.
- Strobe h_total=99 with matching valid values mid-frame → `cfg_pending`=1 until FB. Old line length 800 holds until FB; from the next `px`=0, line length = 100.
- Two strobes within one frame (h_total 99, then 199) → the next frame's line length = 200.
- Strobe coincident with FB (h_total=99) → `cfg_pending` never asserts; the first line of the new frame is 100 cycles.
- Strobe with h_disp_end=900 > h_total=799 → `cfg_err` pulse one cycle later; `cfg_pending` stays 0; timing unchanged.
- Assert `rst_n`=0 during PEND at `px`=300 → all outputs go to their reset values immediately; after release, 800×525 timing with no pending apply.
